multiphase_clock_gen: RTL and testbench

//  Synthesisable N-channel clock/pulse generator; successor to the single fixed-frequency clock stimulus.

---
 rtl/mpclk_pkg.sv | 19 +
 rtl/mpclk_channel.sv | 152 +++++++++++++++
 rtl/multiphase_clock_gen.sv | 68 ++++++
 tb/tb_multiphase_clock_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mpclk_pkg.sv
// Shared types and helpers for the multiphase clock generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mpclk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int MAX_NCH = 16;

    // Periods below 2 cannot produce a high and a low phase, so clamp them.
    function automatic logic [31:0] eff_period(input logic [31:0] p);
        return (p < 32'd2) ? 32'd2 : p;
    endfunction

endpackage

// File: rtl/mpclk_channel.sv
// One programmable clock channel: IDLE/DELAY/RUN FSM, period counter, shadow config.
// Latency: ckout/ckoutb lag the FSM state by one clk; writes to a non-running channel apply on the accept edge.
// Backpressure: pending stays high while a write to a running channel waits for the period wrap.
// Ports: clk/rst; wr strobe with wr_en/wr_period/wr_high/wr_phase; pending, ckout, ckoutb, active out.
// Optional MPCLK_CYCLE_CNT_EN adds cyc_cnt (completed RUN periods, cleared on IDLE entry).
module mpclk_channel
    import mpclk_pkg::*;
#(
    parameter int   CW       = 16,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_period,
    input  logic [CW-1:0] wr_high,
    input  logic [CW-1:0] wr_phase,
    output logic          pending,
`ifdef MPCLK_CYCLE_CNT_EN
    output logic [CW-1:0] cyc_cnt,
`endif
    output logic          ckout,
    output logic          ckoutb,
    output logic          active
);

    // Phase is never needed from the shadow: a write to a running channel
    // restarts without re-delay, and other states apply the write at once.
    typedef struct packed {
        logic          en;
        logic [CW-1:0] period;
        logic [CW-1:0] high;
    } shadow_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] dly_q, dly_d;
    logic [CW-1:0] per_q, per_d;
    logic [CW-1:0] high_q, high_d;
    shadow_t       shd_q, shd_d;
    logic          pend_q, pend_d;
    logic          wrap;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dly_d   = dly_q;
        per_d   = per_q;
        high_d  = high_q;
        shd_d   = shd_q;
        pend_d  = pend_q;
        wrap    = 1'b0;

        case (state_q)
            IDLE: ;
            DELAY: begin
                if (dly_q <= CW'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    dly_d = dly_q - CW'(1);
                end
            end
            RUN: begin
                if (cnt_q == per_q - CW'(1)) begin
                    wrap  = 1'b1;
                    cnt_d = '0;
                    // Deferred config lands only on a period boundary.
                    if (pend_q) begin
                        pend_d = 1'b0;
                        if (!shd_q.en) begin
                            state_d = IDLE;
                        end else begin
                            per_d  = CW'(eff_period(32'(shd_q.period)));
                            high_d = shd_q.high;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr) begin
            shd_d = '{en: wr_en, period: wr_period, high: wr_high};
            if (state_q == RUN) begin
                pend_d = 1'b1;
            end else begin
                pend_d = 1'b0;
                per_d  = CW'(eff_period(32'(wr_period)));
                high_d = wr_high;
                cnt_d  = '0;
                if (!wr_en) begin
                    state_d = IDLE;
                end else if (wr_phase == '0) begin
                    state_d = RUN;
                end else begin
                    state_d = DELAY;
                    dly_d   = wr_phase;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dly_q   <= '0;
            per_q   <= '0;
            high_q  <= '0;
            shd_q   <= '0;
            pend_q  <= 1'b0;
            ckout   <= IDLE_LVL;
            ckoutb  <= ~IDLE_LVL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dly_q   <= dly_d;
            per_q   <= per_d;
            high_q  <= high_d;
            shd_q   <= shd_d;
            pend_q  <= pend_d;
            // high=0 gives constant low, high>=period constant high.
            if (state_q == RUN) begin
                ckout  <= (cnt_q < high_q);
                ckoutb <= ~(cnt_q < high_q);
            end else begin
                ckout  <= IDLE_LVL;
                ckoutb <= ~IDLE_LVL;
            end
        end
    end

`ifdef MPCLK_CYCLE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt <= '0;
        end else if (state_d == IDLE && state_q != IDLE) begin
            cyc_cnt <= '0;
        end else if (wrap) begin
            cyc_cnt <= cyc_cnt + CW'(1);
        end
    end
`endif

    assign pending = pend_q;
    assign active  = (state_q == RUN);

endmodule

// File: rtl/multiphase_clock_gen.sv
// NCH independently programmable clock/pulse outputs divided from one reference clock.
// Latency: accepted writes take effect on the accept edge (or next period wrap if running); outputs lag state by one clk.
// Backpressure: cfg_ready is low while the addressed channel still holds an unapplied write.
// Ports: clk, rst (sync, active high); cfg_valid/cfg_ready/cfg_ch/cfg_en/cfg_period/cfg_high/cfg_phase write port;
// ckout, ckoutb, active per channel. Macro MPCLK_CYCLE_CNT_EN adds cyc_cnt (NCH*CW packed, channel 0 in LSBs).
module multiphase_clock_gen
    import mpclk_pkg::*;
#(
    parameter int   NCH      = 4,
    parameter int   CW       = 16,
    parameter logic IDLE_LVL = 1'b0,
    localparam int  CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CHW-1:0]    cfg_ch,
    input  logic              cfg_en,
    input  logic [CW-1:0]     cfg_period,
    input  logic [CW-1:0]     cfg_high,
    input  logic [CW-1:0]     cfg_phase,
`ifdef MPCLK_CYCLE_CNT_EN
    output logic [NCH*CW-1:0] cyc_cnt,
`endif
    output logic [NCH-1:0]    ckout,
    output logic [NCH-1:0]    ckoutb,
    output logic [NCH-1:0]    active
);

    logic [NCH-1:0] pending;
    logic [NCH-1:0] wr;

    // Out-of-range channel numbers read as ready and the write is dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH && i < MAX_NCH; i++) begin
            if (cfg_ch == CHW'(i)) begin
                cfg_ready = ~pending[i];
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign wr[i] = cfg_valid && cfg_ready && (cfg_ch == CHW'(i));

        mpclk_channel #(
            .CW       (CW),
            .IDLE_LVL (IDLE_LVL)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .wr        (wr[i]),
            .wr_en     (cfg_en),
            .wr_period (cfg_period),
            .wr_high   (cfg_high),
            .wr_phase  (cfg_phase),
            .pending   (pending[i]),
`ifdef MPCLK_CYCLE_CNT_EN
            .cyc_cnt   (cyc_cnt[i*CW +: CW]),
`endif
            .ckout     (ckout[i]),
            .ckoutb    (ckoutb[i]),
            .active    (active[i])
        );
    end

endmodule

// File: tb/tb_multiphase_clock_gen.sv
// Directed bench for multiphase_clock_gen (NCH=4, CW=16, IDLE_LVL=0).
// Latency: n/a.
// Backpressure: n/a.
module tb_multiphase_clock_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic        cfg_en;
    logic [15:0] cfg_period;
    logic [15:0] cfg_high;
    logic [15:0] cfg_phase;
    logic [3:0]  ckout;
    logic [3:0]  ckoutb;
    logic [3:0]  active;
`ifdef MPCLK_CYCLE_CNT_EN
    logic [63:0] cyc_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multiphase_clock_gen dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_en     (cfg_en),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_phase  (cfg_phase),
`ifdef MPCLK_CYCLE_CNT_EN
        .cyc_cnt    (cyc_cnt),
`endif
        .ckout      (ckout),
        .ckoutb     (ckoutb),
        .active     (active)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents one write and returns 1ns after the edge that sampled it.
    task automatic write(input logic [1:0] ch, input logic en, input logic [15:0] per,
                         input logic [15:0] high, input logic [15:0] ph);
        cfg_ch     = ch;
        cfg_en     = en;
        cfg_period = per;
        cfg_high   = high;
        cfg_phase  = ph;
        cfg_valid  = 1'b1;
        tick();
        cfg_valid  = 1'b0;
    endtask

    initial begin
        logic prev;
        bit   found;

        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_en = 1'b0;
        cfg_period = '0; cfg_high = '0; cfg_phase = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_ckout", 32'(ckout), 32'h0);
        chk("rst_ckoutb", 32'(ckoutb), 32'hF);
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_ready", 32'(cfg_ready), 32'h1);
        rst = 1'b0;
        tick();
        chk("idle_ckout", 32'(ckout), 32'h0);

        // ch0 P=4 H=2 phase=0: 1,1,0,0 from the edge after accept
        write(2'd0, 1'b1, 16'd4, 16'd2, 16'd0);
        chk("ch0_active_at_accept", 32'(active[0]), 32'h1);
        chk("ch0_ready_after_accept", 32'(cfg_ready), 32'h1);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("ch0_ckout", 32'(ckout[0]), 32'((k % 4) < 2));
            chk("ch0_ckoutb", 32'(ckoutb[0]), 32'(!((k % 4) < 2)));
        end

        // ch1 P=6 H=3 phase=5: RUN from accept+5, first rise at accept+6
        write(2'd1, 1'b1, 16'd6, 16'd3, 16'd5);
        chk("ch1_delay_inactive", 32'(active[1]), 32'h0);
        for (int j = 1; j <= 12; j++) begin
            tick();
            chk("ch1_ckout", 32'(ckout[1]), 32'((j >= 6) && (((j - 6) % 6) < 3)));
            chk("ch1_active", 32'(active[1]), 32'(j >= 5));
        end

        // Find a ch0 rising edge: counter is then 1, so the next edge is mid-period
        found = 1'b0;
        for (int n = 0; n < 12 && !found; n++) begin
            prev = ckout[0];
            tick();
            if (!prev && ckout[0]) found = 1'b1;
        end
        chk("ch0_rise_seen", 32'(found), 32'h1);

        // Mid-period change to P=8 H=4: old period finishes, new one starts after wrap
        write(2'd0, 1'b1, 16'd8, 16'd4, 16'd0);
        chk("ch0_pending_ready", 32'(cfg_ready), 32'h0);
        chk("ch0_old_hi", 32'(ckout[0]), 32'h1);
        tick();
        chk("ch0_pending_ready2", 32'(cfg_ready), 32'h0);
        chk("ch0_old_lo", 32'(ckout[0]), 32'h0);
        tick();
        chk("ch0_ready_after_wrap", 32'(cfg_ready), 32'h1);
        chk("ch0_old_lo2", 32'(ckout[0]), 32'h0);
        for (int j = 4; j < 16; j++) begin
            tick();
            chk("ch0_new_period", 32'(ckout[0]), 32'(((j - 4) % 8) < 4));
        end

        // period=0 and period=1 behave as period 2
        write(2'd2, 1'b1, 16'd0, 16'd1, 16'd0);
        for (int j = 1; j <= 6; j++) begin
            tick();
            chk("p0_toggle", 32'(ckout[2]), 32'(j % 2));
        end
        write(2'd3, 1'b1, 16'd1, 16'd1, 16'd0);
        for (int j = 1; j <= 6; j++) begin
            tick();
            chk("p1_toggle", 32'(ckout[3]), 32'(j % 2));
        end

        // high=0 -> stuck low yet active; high>=period -> stuck high
        write(2'd2, 1'b1, 16'd4, 16'd0, 16'd0);
        repeat (4) tick();
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("h0_low", 32'(ckout[2]), 32'h0);
            chk("h0_active", 32'(active[2]), 32'h1);
        end
        write(2'd3, 1'b1, 16'd4, 16'd10, 16'd0);
        repeat (4) tick();
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("hbig_high", 32'(ckout[3]), 32'h1);
        end

        // Reset mid-RUN with a write still pending on ch0
        write(2'd0, 1'b0, 16'd8, 16'd4, 16'd0);
        chk("pend_before_rst", 32'(cfg_ready), 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ckout", 32'(ckout), 32'h0);
        chk("midrst_ckoutb", 32'(ckoutb), 32'hF);
        chk("midrst_active", 32'(active), 32'h0);
        for (int c = 0; c < 4; c++) begin
            cfg_ch = 2'(c);
            #1;
            chk("midrst_ready", 32'(cfg_ready), 32'h1);
        end
        tick();
        chk("post_rst_idle", 32'(ckout), 32'h0);

`ifdef MPCLK_CYCLE_CNT_EN
        chk("cyc_rst", cyc_cnt[31:0], 32'h0);
        write(2'd0, 1'b1, 16'd4, 16'd2, 16'd0);
        chk("cyc_start", 32'(cyc_cnt[15:0]), 32'h0);
        repeat (12) tick();
        chk("cyc_three", 32'(cyc_cnt[15:0]), 32'h3);
        tick();
        chk("cyc_hold", 32'(cyc_cnt[15:0]), 32'h3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
